// File: rtl/result_collector_if.sv
// rtl/result_collector_if.sv - result capture and host readout handshake bundle
interface result_collector_if #(
    parameter int DW = 10
);
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_row;
    logic [1:0]    out_col;

    // Producer/host side: drives results in and acceptance of the head entry
    modport master (
        output res_valid,
        output res_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_col
    );

    // Collector side
    modport slave (
        input  res_valid,
        input  res_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_row,
        output out_col
    );
endinterface

// File: rtl/result_collector.sv
// rtl/result_collector.sv - tags 3x3 matmul results with row/col and buffers them in a FIFO
module result_collector #(
    parameter int DW    = 10,
    parameter int DEPTH = 16,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    result_collector_if.slave   bus,
    output logic                frame_done,
    output logic [7:0]          frame_count,
    output logic                overflow,
    output logic [LW-1:0]       level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef struct packed {
        logic [1:0]    row;
        logic [1:0]    col;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [1:0]    tag_row;
    logic [1:0]    tag_col;
    logic          not_empty;
    logic          push_req;
    logic          pop;
    logic          push_ok;
    logic          tag_wrap;

    // Handshake decode; clear masks both the incoming result and any pop
    always_comb begin
        not_empty = (level_q != '0);
        push_req  = bus.res_valid & ~clear;
        pop       = not_empty & bus.out_ready & ~clear;
        // A full FIFO still accepts when the head leaves in the same cycle
        push_ok   = push_req & ((level_q != FULL_LEVEL) | pop);
        tag_wrap  = push_req & (tag_row == 2'd2) & (tag_col == 2'd2);
    end

    // Entry storage: only written by accepted pushes, no reset needed
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= '{row: tag_row, col: tag_col, data: bus.res_data};
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push_ok, pop})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // Row-major tag counters; they advance on dropped results too so tags stay aligned
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tag_row <= 2'd0;
            tag_col <= 2'd0;
        end else if (push_req) begin
            if (tag_col == 2'd2) begin
                tag_col <= 2'd0;
                tag_row <= (tag_row == 2'd2) ? 2'd0 : tag_row + 2'd1;
            end else begin
                tag_col <= tag_col + 2'd1;
            end
        end
    end

    // Status: frame pulse/count on tag wrap, sticky overflow on a dropped result
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
            overflow    <= 1'b0;
        end else if (clear) begin
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_done <= tag_wrap;
            if (tag_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head presentation; outputs read as zero while the FIFO is empty
    always_comb begin
        head          = mem[rd_ptr];
        bus.out_valid = not_empty;
        bus.out_data  = not_empty ? head.data : '0;
        bus.out_row   = not_empty ? head.row  : 2'd0;
        bus.out_col   = not_empty ? head.col  : 2'd0;
        level         = level_q;
    end

endmodule
